// File: rtl/wb_stage_pkg.sv
// Shared widths, MEM->WB bus layout and mem_inst bit indices for the write-back stage.
package wb_stage_pkg;

    localparam int unsigned BUS_WD = 150;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned MI_W   = 12;

    // One-hot mem_inst bit positions
    localparam int unsigned MI_LB  = 0;
    localparam int unsigned MI_LBU = 1;
    localparam int unsigned MI_LH  = 2;
    localparam int unsigned MI_LHU = 3;
    localparam int unsigned MI_LW  = 4;
    localparam int unsigned MI_LWL = 5;
    localparam int unsigned MI_LWR = 6;
    localparam int unsigned MI_SB  = 7;
    localparam int unsigned MI_SH  = 8;
    localparam int unsigned MI_SW  = 9;
    localparam int unsigned MI_SWL = 10;
    localparam int unsigned MI_SWR = 11;

    // MEM->WB payload, MSB first
    typedef struct packed {
        logic              res_from_mem;
        logic [MI_W-1:0]   mem_inst;
        logic [DATA_W-1:0] rt_value;
        logic [DATA_W-1:0] data_rdata;
        logic [1:0]        rdata_type;
        logic              ex;
        logic              gr_we;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] result;
        logic [31:0]       pc;
    } ms_to_ws_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load-data extraction (lb/lbu/lh/lhu/lw/lwl/lwr) from the captured DCache word.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [MI_W-1:0]   mem_inst,
    input  logic [1:0]        rdata_type,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic [DATA_W-1:0] rt_value,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store bits travel with the payload but play no part in load extraction
    logic unused_store_bits;
    assign unused_store_bits = ^mem_inst[MI_SWR:MI_SB];

    // Byte/half lane select followed by per-opcode merge; no load bit falls back to the full word
    always_comb begin
        byte_sel  = data_rdata[7:0];
        half_sel  = data_rdata[15:0];
        load_data = data_rdata;

        case (rdata_type)
            2'd0:    byte_sel = data_rdata[7:0];
            2'd1:    byte_sel = data_rdata[15:8];
            2'd2:    byte_sel = data_rdata[23:16];
            default: byte_sel = data_rdata[31:24];
        endcase

        if (rdata_type[1]) begin
            half_sel = data_rdata[31:16];
        end

        if (mem_inst[MI_LB]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (mem_inst[MI_LBU]) begin
            load_data = {24'h0, byte_sel};
        end else if (mem_inst[MI_LH]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (mem_inst[MI_LHU]) begin
            load_data = {16'h0, half_sel};
        end else if (mem_inst[MI_LW]) begin
            load_data = data_rdata;
        end else if (mem_inst[MI_LWL]) begin
            case (rdata_type)
                2'd0:    load_data = {data_rdata[7:0],  rt_value[23:0]};
                2'd1:    load_data = {data_rdata[15:0], rt_value[15:0]};
                2'd2:    load_data = {data_rdata[23:0], rt_value[7:0]};
                default: load_data = data_rdata;
            endcase
        end else if (mem_inst[MI_LWR]) begin
            case (rdata_type)
                2'd0:    load_data = data_rdata;
                2'd1:    load_data = {rt_value[31:24], data_rdata[31:8]};
                2'd2:    load_data = {rt_value[31:16], data_rdata[31:16]};
                default: load_data = {rt_value[31:8],  data_rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM->WB payload, extracts load data, drives the GPR
// write port and the WB->ID forwarding path.
// Optional: define WB_DEBUG_TRACE_EN to add the debug_wb_* commit trace ports.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              ws_allowin,
    input  logic              ms_to_ws_valid,
    input  logic [BUS_WD-1:0] ms_to_ws_bus,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] WB_dest,
    output logic [DATA_W-1:0] WB_result
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
`endif
);

    logic              ws_valid;
    logic              ws_ready_go;
    ms_to_ws_t         bus_r;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] final_data;

    // No stall source yet; kept structural so one can be added later
    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // Stage valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    // Payload register; holds across gaps so forwarding data stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_r <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            bus_r <= ms_to_ws_t'(ms_to_ws_bus);
        end
    end

    load_align u_load_align (
        .mem_inst   (bus_r.mem_inst),
        .rdata_type (bus_r.rdata_type),
        .data_rdata (bus_r.data_rdata),
        .rt_value   (bus_r.rt_value),
        .load_data  (load_data)
    );

    // Write port and forwarding path, combinational from the payload register
    always_comb begin
        final_data = bus_r.res_from_mem ? load_data : bus_r.result;
        rf_we      = ws_valid && bus_r.gr_we && !bus_r.ex && (bus_r.dest != ADDR_W'(0));
        rf_waddr   = bus_r.dest;
        rf_wdata   = final_data;
        WB_dest    = bus_r.dest & {ADDR_W{rf_we}};
        WB_result  = final_data;
    end

`ifdef WB_DEBUG_TRACE_EN
    // Commit trace for the reference-model comparator
    always_comb begin
        debug_wb_pc       = ws_valid ? bus_r.pc : 32'h0;
        debug_wb_rf_wen   = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end
`else
    // PC is only consumed by the debug trace
    logic unused_pc;
    assign unused_pc = ^bus_r.pc;
`endif

endmodule
